float_mult_seq: RTL and testbench

- Multi-cycle IEEE-754 single-precision multiplier with a valid/ready handshake on both sides.
- An FSM sequences unpack, an iterative 24-step shift-add mantissa multiply, normalize and pack.
- It replaces the wide combinational mantissa product with one adder.
- It sits between a requester and a result consumer, and holds each result until the consumer accepts it.

---
 rtl/float_mult_seq.sv | 184 ++++++++++++++++++
 tb/tb_float_mult_seq.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/float_mult_seq.sv
// Multi-cycle IEEE-754 single-precision multiplier using one shift-add adder.
// Valid/ready on both sides; the result is held until the consumer takes it.
module float_mult_seq #(
  parameter int MANT_W = 24
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x,
  input  logic [31:0] y,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        zero,
  output logic        underflow,
  output logic        overflow,
  output logic        nan,
  output logic        busy
);

  localparam int P_W    = 2 * MANT_W;
  localparam int FRAC_W = MANT_W - 1;
  localparam int CNT_W  = $clog2(MANT_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_MULT,
    S_NORM,
    S_DONE
  } state_t;

  state_t             state_reg;
  logic [31:0]        x_reg, y_reg;
  logic               sign_reg;
  logic [7:0]         ea_reg, eb_reg;
  logic [P_W-1:0]     mcand_reg;
  logic [MANT_W-1:0]  mplier_reg;
  logic [P_W-1:0]     p_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               special_reg;
  logic [31:0]        special_res_reg;
  logic               special_zero_reg, special_nan_reg;
  logic [31:0]        result_reg;
  logic               zero_reg, underflow_reg, overflow_reg, nan_reg;
  logic               out_valid_reg;

  // Operand classification, evaluated on the latched operands during UNPACK.
  logic       x_nan, y_nan, x_inf, y_inf, x_zero, y_zero;
  logic       nan_case, zero_case, inf_case;
  logic       sign_next;
  logic [31:0] special_res_next;

  always_comb begin
    x_zero    = (x_reg[30:23] == 8'h00);
    y_zero    = (y_reg[30:23] == 8'h00);
    x_nan     = (x_reg[30:23] == 8'hFF) && (x_reg[22:0] != 23'd0);
    y_nan     = (y_reg[30:23] == 8'hFF) && (y_reg[22:0] != 23'd0);
    x_inf     = (x_reg[30:23] == 8'hFF) && (x_reg[22:0] == 23'd0);
    y_inf     = (y_reg[30:23] == 8'hFF) && (y_reg[22:0] == 23'd0);
    sign_next = x_reg[31] ^ y_reg[31];
    nan_case  = x_nan || y_nan || (x_inf && y_zero) || (y_inf && x_zero);
    zero_case = x_zero || y_zero;
    inf_case  = x_inf || y_inf;
    if (nan_case)
      special_res_next = 32'h7FC0_0000;
    else if (zero_case)
      special_res_next = {sign_next, 31'd0};
    else
      special_res_next = {sign_next, 8'hFF, 23'd0};
  end

  // Normalisation of the finished product; exponent kept signed to catch both range ends.
  logic signed [9:0] e_norm;
  logic [FRAC_W-1:0] mant_norm;

  always_comb begin
    e_norm = $signed({2'b00, ea_reg}) + $signed({2'b00, eb_reg}) - 10'sd127;
    if (p_reg[P_W-1]) begin
      mant_norm = p_reg[P_W-2 -: FRAC_W];
      e_norm    = e_norm + 10'sd1;
    end else begin
      mant_norm = p_reg[P_W-3 -: FRAC_W];
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg        <= S_IDLE;
      x_reg            <= '0;
      y_reg            <= '0;
      sign_reg         <= 1'b0;
      ea_reg           <= '0;
      eb_reg           <= '0;
      mcand_reg        <= '0;
      mplier_reg       <= '0;
      p_reg            <= '0;
      cnt_reg          <= '0;
      special_reg      <= 1'b0;
      special_res_reg  <= '0;
      special_zero_reg <= 1'b0;
      special_nan_reg  <= 1'b0;
      result_reg       <= '0;
      zero_reg         <= 1'b0;
      underflow_reg    <= 1'b0;
      overflow_reg     <= 1'b0;
      nan_reg          <= 1'b0;
      out_valid_reg    <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (in_valid) begin
            x_reg         <= x;
            y_reg         <= y;
            zero_reg      <= 1'b0;
            underflow_reg <= 1'b0;
            overflow_reg  <= 1'b0;
            nan_reg       <= 1'b0;
            state_reg     <= S_UNPACK;
          end
        end
        S_UNPACK: begin
          sign_reg         <= sign_next;
          ea_reg           <= x_reg[30:23];
          eb_reg           <= y_reg[30:23];
          mcand_reg        <= {{(P_W-MANT_W){1'b0}}, 1'b1, x_reg[FRAC_W-1:0]};
          mplier_reg       <= {1'b1, y_reg[FRAC_W-1:0]};
          p_reg            <= '0;
          cnt_reg          <= '0;
          special_reg      <= nan_case || zero_case || inf_case;
          special_res_reg  <= special_res_next;
          special_nan_reg  <= nan_case;
          special_zero_reg <= !nan_case && zero_case;
          // Special operands skip MULT; NORM commits every result so DONE has one source.
          state_reg        <= (nan_case || zero_case || inf_case) ? S_NORM : S_MULT;
        end
        S_MULT: begin
          if (mplier_reg[0])
            p_reg <= p_reg + mcand_reg;
          mcand_reg  <= mcand_reg << 1;
          mplier_reg <= mplier_reg >> 1;
          cnt_reg    <= cnt_reg + 1'b1;
          if (cnt_reg == CNT_W'(MANT_W - 1))
            state_reg <= S_NORM;
        end
        S_NORM: begin
          if (special_reg) begin
            result_reg <= special_res_reg;
            zero_reg   <= special_zero_reg;
            nan_reg    <= special_nan_reg;
          end else if (e_norm >= 10'sd255) begin
            result_reg   <= {sign_reg, 8'hFF, 23'd0};
            overflow_reg <= 1'b1;
          end else if (e_norm <= 10'sd0) begin
            result_reg    <= {sign_reg, 31'd0};
            underflow_reg <= 1'b1;
          end else begin
            result_reg <= {sign_reg, e_norm[7:0], mant_norm};
          end
          out_valid_reg <= 1'b1;
          state_reg     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            state_reg     <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_reg == S_IDLE);
  assign busy      = (state_reg != S_IDLE);
  assign out_valid = out_valid_reg;
  assign result    = result_reg;
  assign zero      = zero_reg;
  assign underflow = underflow_reg;
  assign overflow  = overflow_reg;
  assign nan       = nan_reg;

endmodule

// File: tb/tb_float_mult_seq.sv
// Scoreboard bench for float_mult_seq: directed cases, backpressure, mid-op reset
// and randomized operands checked against a plain-arithmetic reference model.
module tb_float_mult_seq;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] x = '0, y = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        zero, underflow, overflow, nan, busy;

  float_mult_seq #(.MANT_W(24)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready), .x(x), .y(y),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .underflow(underflow), .overflow(overflow), .nan(nan),
    .busy(busy)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  bit rand_bp = 1'b0;

  // flags packed as {zero, underflow, overflow, nan}
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic [3:0]  f;
    int          lat;
    longint      acc;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: exact 48-bit integer product of the mantissas, truncated.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic [3:0] f, output int lat);
    bit an, bn, ai, bi, az, bz, s;
    longint unsigned p;
    int e;
    logic [22:0] m;
    an = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    bn = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    ai = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    bi = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    az = (a[30:23] == 0);
    bz = (b[30:23] == 0);
    s  = a[31] ^ b[31];
    f = 4'b0000;
    lat = 2;
    if (an || bn || (ai && bz) || (bi && az)) begin
      r = 32'h7FC00000; f = 4'b0001;
    end else if (az || bz) begin
      r = {s, 31'd0}; f = 4'b1000;
    end else if (ai || bi) begin
      r = {s, 8'hFF, 23'd0};
    end else begin
      lat = 26;
      p = longint'({1'b1, a[22:0]}) * longint'({1'b1, b[22:0]});
      e = int'(a[30:23]) + int'(b[30:23]) - 127;
      if (p >= (64'd1 << 47)) begin
        e = e + 1;
        m = p[46:24];
      end else begin
        m = p[45:23];
      end
      if (e >= 255) begin
        r = {s, 8'hFF, 23'd0}; f = 4'b0010;
      end else if (e <= 0) begin
        r = {s, 31'd0}; f = 4'b0100;
      end else begin
        r = {s, 8'(e), m};
      end
    end
  endfunction

  // Present operands, wait for acceptance, then record the expectation.
  task automatic issue_nowait(input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] er, input logic [3:0] ef, input int lat);
    exp_t e;
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1; x = a; y = b;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      tests++; fails++;
      $display("[TB] FAIL accept_timeout: in_ready stayed 0 expected 1");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    e.a = a; e.b = b; e.r = er; e.f = ef; e.lat = lat; e.acc = cyc;
    sb.push_back(e);
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(sb.size() == 0 && in_ready) && n < 300);
    if (!(sb.size() == 0 && in_ready)) begin
      tests++; fails++;
      $display("[TB] FAIL done_timeout: pending %0d expected 0", sb.size());
    end
  endtask

  task automatic run_model(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic [3:0] f;
    int lat;
    model(a, b, r, f, lat);
    issue_nowait(a, b, r, f, lat);
    wait_done();
  endtask

  // Monitor: compare on every rising edge of out_valid.
  initial begin : monitor
    logic prev_ov;
    exp_t e;
    prev_ov = 1'b0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        prev_ov = 1'b0;
      end else begin
        if (out_valid && !prev_ov) begin
          if (sb.size() == 0) begin
            tests++; fails++;
            $display("[TB] FAIL unexpected_output: result %h expected none", result);
          end else begin
            e = sb.pop_front();
            check("result", result, e.r);
            check("flags", {28'd0, zero, underflow, overflow, nan}, {28'd0, e.f});
            check("latency", 32'(cyc - e.acc), 32'(e.lat));
            check("in_ready_done", {31'd0, in_ready}, 32'd0);
            $display("[TB] %h * %h -> %h flags %b", e.a, e.b, result,
                     {zero, underflow, overflow, nan});
          end
        end
        prev_ov = out_valid;
      end
    end
  end

  initial begin : bp_driver
    forever begin
      @(negedge clk);
      if (rand_bp) out_ready = 1'($urandom_range(0, 1));
    end
  end

  logic [31:0] dir_a [9] = '{32'h3FC00000, 32'h3FC00000, 32'h3F800001, 32'h00000000,
                             32'h7F800000, 32'hFF800000, 32'h7F000000, 32'h00800000,
                             32'hC0400000};
  logic [31:0] dir_b [9] = '{32'h40000000, 32'h3FC00000, 32'h3F800001, 32'hC0000000,
                             32'h00000000, 32'h40000000, 32'h7F000000, 32'h00800000,
                             32'h40800000};
  logic [31:0] dir_r [9] = '{32'h40400000, 32'h40100000, 32'h3F800002, 32'h80000000,
                             32'h7FC00000, 32'hFF800000, 32'h7F800000, 32'h00000000,
                             32'hC1400000};
  logic [3:0]  dir_f [9] = '{4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0001, 4'b0000,
                             4'b0010, 4'b0100, 4'b0000};
  int          dir_l [9] = '{26, 26, 26, 2, 2, 2, 26, 26, 26};

  initial begin
    logic [31:0] a, b;
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_flags", {28'd0, zero, underflow, overflow, nan}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 9; i++) begin
      issue_nowait(dir_a[i], dir_b[i], dir_r[i], dir_f[i], dir_l[i]);
      wait_done();
    end

    // Backpressure: result held, in_ready low, new operands ignored.
    out_ready = 1'b0;
    issue_nowait(32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000, 26);
    for (int n = 0; n < 100 && !out_valid; n++) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1; x = 32'h40000000; y = 32'h40000000;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_result", result, 32'h40400000);
      check("bp_flags", {28'd0, zero, underflow, overflow, nan}, 32'd0);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    check("bp_release_valid", {31'd0, out_valid}, 32'd0);
    issue_nowait(32'h40000000, 32'h40000000, 32'h40800000, 4'b0000, 26);
    wait_done();

    // Reset during MULT step 10.
    issue_nowait(32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000, 26);
    repeat (11) @(posedge clk);
    @(negedge clk);
    resetn = 1'b0;
    @(posedge clk);
    #1;
    sb.delete();
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_flags", {28'd0, zero, underflow, overflow, nan}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    issue_nowait(32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000, 26);
    wait_done();

    // Randomized operands with random consumer backpressure.
    rand_bp = 1'b1;
    for (int i = 0; i < 60; i++) begin
      for (int j = 0; j < 2; j++) begin
        logic [7:0] e;
        logic [22:0] m;
        int sel;
        sel = $urandom_range(0, 9);
        if (sel == 0) e = 8'h00;
        else if (sel == 1) e = 8'hFF;
        else e = 8'($urandom_range(1, 254));
        m = 23'($urandom);
        if (sel == 1 && $urandom_range(0, 1) == 1) m = '0;
        if (j == 0) a = {1'($urandom), e, m};
        else b = {1'($urandom), e, m};
      end
      run_model(a, b);
    end
    rand_bp = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    wait_done();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
